uart_regs_bridge: RTL and testbench
===================================

# uart_regs_bridge

Host-side command engine feeding the design interface wrapper: parses a byte stream from the UART receiver into register and memory transactions, drives the interface registers with per-register valid pulses, reads back result registers / memory, and returns response bytes to the UART transmitter. Sits between the UART RX/TX byte layer and the design interface wrapper.

## Interface
- NUM_REGS_PER_DIR, 8: number of 32-bit interface registers per direction
- TIMEOUT_CYCLES, 1_000_000: inter-byte timeout, used only with the timeout feature
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- rx_byte  input  8  received byte
- rx_byte_valid  input  1  one-cycle strobe; no backpressure possible
- tx_byte  output  8  response byte
- tx_byte_valid  output  1  response byte valid
- tx_byte_ready  input  1  transmitter accepts byte
- intrfc_regs_in  output  32 x NUM_REGS_PER_DIR  host-written registers
- intrfc_regs_in_valid_pulse  output  NUM_REGS_PER_DIR  one-cycle pulse per written register
- intrfc_regs_out  input  32 x NUM_REGS_PER_DIR  design result registers
- mem_addr  output  9  memory address
- mem_wr_data  output  32  memory write data
- mem_rd_data  input  32  memory read data, 1-cycle synchronous read
- mem_wr  output  1  one-cycle write strobe
- busy  output  1  high whenever state != IDLE

## Operation
- Opcode byte [7:6]: 00 REG_WR, 01 REG_RD, 10 MEM_WR, 11 MEM_RD; bits [5:0] ignored. Multi-byte fields are sent MSB first.
- REG_WR: op, idx, d3..d0. Updates regs_in[idx], pulses valid[idx], responds ACK 0xA5.
- REG_RD: op, idx. Responds with regs_out[idx] as 4 bytes, MSB first.
- MEM_WR: op, addrH, addrL, d3..d0. Address = {addrH[0], addrL}; addrH[7:1] ignored. Pulses mem_wr, responds 0xA5.
- MEM_RD: op, addrH, addrL. Drives mem_addr, waits 1 cycle, captures mem_rd_data, responds with 4 bytes.
- If idx >= NUM_REGS_PER_DIR: all command bytes are consumed, no write occurs, and the response is ERR 0xEE (1 byte).
- FSM states: IDLE -> GET_IDX | GET_ADDR_H -> GET_ADDR_L -> GET_DATA(4 bytes) -> EXEC -> MEM_WAIT (MEM_RD only) -> SEND -> IDLE.
  - REG_RD and REG_WR go from GET_IDX to EXEC or GET_DATA respectively.
- rx bytes arriving in EXEC, MEM_WAIT or SEND are dropped. No queueing.
- Reset values:
  - intrfc_regs_in all 0, valid pulses 0, mem_addr 0, mem_wr_data 0, mem_wr 0.
  - tx_byte 0, tx_byte_valid 0, busy 0, FSM in IDLE.
- Reset asserted mid-command aborts the command. No pulse or response is produced.

## Timing
- Last command byte is sampled at edge N; EXEC is occupied during cycle N+1.
- REG_WR / MEM_WR:
  - Register or memory update and the valid pulse / mem_wr are registered at edge N+1.
  - The pulse is high for exactly cycle N+1..N+2, and never longer than one cycle.
- MEM_RD: mem_addr is stable from edge N+1; mem_rd_data is captured at edge N+3.
- SEND:
  - tx_byte_valid rises the cycle after EXEC (REG_*) or after capture (MEM_RD).
  - A byte transfers on any edge where valid && ready.
  - The next byte is presented the following cycle; valid stays high between bytes if ready was high.
  - tx_byte must stay stable while valid && !ready.
  - After the final transfer: tx_byte_valid = 0 and the FSM returns to IDLE on the same edge.
- Minimum REG_RD turnaround with tx_byte_ready tied high: first response byte valid 2 cycles after the idx byte edge.

## Configuration
- UART_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on every accepted rx byte and counts in the GET_* states.
  - At TIMEOUT_CYCLES with no new byte, the FSM returns to IDLE and the partial command is discarded silently (no response).
  - The counter is 0 in all other states.
- Not defined: no counter logic; the FSM waits indefinitely for the remaining bytes.

## Structure
- Package uart_bridge_pkg holds:
  - opcode enum
  - ACK_BYTE 0xA5 and ERR_BYTE 0xEE
  - FSM state enum
  - MEM_ADDR_W = 9
- Sub-module uart_bridge_resp_ser:
  - Load interface: 32-bit word plus byte count 1 or 4.
  - Shifts bytes MSB first under the tx handshake and asserts done on the last transfer.

## Test plan
- REG_WR 0x00,0x01,0xDE,0xAD,0xBE,0xEF -> regs_in[1]=0xDEADBEEF; valid_pulse = 0b0000_0010 for exactly 1 cycle; tx 0xA5.
- regs_out[3]=0x12345678, send 0x40,0x03 -> tx 0x12,0x34,0x56,0x78. Repeat with tx_byte_ready toggling every other cycle: tx_byte held stable while stalled, same byte sequence.
- MEM_WR 0x80,0x01,0x23,0x00,0x00,0x00,0x2A -> mem_addr=0x123, mem_wr_data=0x2A, mem_wr high for 1 cycle, tx 0xA5. Then MEM_RD 0xC0,0x01,0x23 -> tx 0x00,0x00,0x00,0x2A.
- REG_WR with idx=8 (default parameter) -> no pulse, all regs unchanged, tx 0xEE only.
- Reset after byte 3 of a REG_WR, then a full REG_RD of reg 0 -> regs_in all 0, no pulse, response is 4 bytes of regs_out[0].
- With UART_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 0x00,0x02, idle 100 cycles, then send 0x40,0x02 -> no write, no ACK, tx returns regs_out[2].

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART register/memory command bridge.
package uart_bridge_pkg;

    localparam int unsigned MEM_ADDR_W = 9;
    localparam int unsigned DATA_W     = 32;

    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [1:0] {
        OP_REG_WR = 2'b00,
        OP_REG_RD = 2'b01,
        OP_MEM_WR = 2'b10,
        OP_MEM_RD = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_IDX,
        ST_GET_ADDR_H,
        ST_GET_ADDR_L,
        ST_GET_DATA,
        ST_EXEC,
        ST_MEM_WAIT,
        ST_SEND
    } state_e;

    // Command fields gathered while parsing the byte stream
    typedef struct packed {
        opcode_e               op;
        logic [7:0]            idx;
        logic [MEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } cmd_t;

endpackage

// File: rtl/uart_regs_bridge_if.sv
// Byte-stream handshake between the UART RX/TX layer and the command bridge.
interface uart_regs_bridge_if;

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ready;

    modport master (
        output rx_byte, rx_byte_valid, tx_byte_ready,
        input  tx_byte, tx_byte_valid
    );

    modport slave (
        input  rx_byte, rx_byte_valid, tx_byte_ready,
        output tx_byte, tx_byte_valid
    );

endinterface

// File: rtl/uart_bridge_resp_ser.sv
// Response serializer: loads a 1- or 4-byte response and shifts it out MSB first.
module uart_bridge_resp_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        load_four,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready,
    output logic        done_c
);

    logic [23:0] shift_q;
    logic [2:0]  rem_q;
    logic        xfer_c;

    assign xfer_c = tx_byte_valid && tx_byte_ready;
    assign done_c = xfer_c && (rem_q == 3'd1);

    // tx_byte only changes on load or transfer, so it holds while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_byte       <= 8'h00;
            tx_byte_valid <= 1'b0;
            shift_q       <= '0;
            rem_q         <= '0;
        end else if (load) begin
            tx_byte_valid <= 1'b1;
            if (load_four) begin
                tx_byte <= load_word[31:24];
                shift_q <= load_word[23:0];
                rem_q   <= 3'd4;
            end else begin
                tx_byte <= load_word[7:0];
                shift_q <= '0;
                rem_q   <= 3'd1;
            end
        end else if (xfer_c) begin
            if (rem_q == 3'd1) begin
                tx_byte_valid <= 1'b0;
                rem_q         <= '0;
            end else begin
                tx_byte <= shift_q[23:16];
                shift_q <= {shift_q[15:0], 8'h00};
                rem_q   <= rem_q - 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_regs_bridge.sv
// UART command engine: parses register/memory commands and returns response bytes.
// Optional inter-byte timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_regs_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned NUM_REGS_PER_DIR = 8,
    parameter int unsigned TIMEOUT_CYCLES   = 1_000_000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    uart_regs_bridge_if.slave                      uart,
    output logic [NUM_REGS_PER_DIR-1:0][DATA_W-1:0] intrfc_regs_in,
    output logic [NUM_REGS_PER_DIR-1:0]            intrfc_regs_in_valid_pulse,
    input  logic [NUM_REGS_PER_DIR-1:0][DATA_W-1:0] intrfc_regs_out,
    output logic [MEM_ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                      mem_wr_data,
    input  logic [DATA_W-1:0]                      mem_rd_data,
    output logic                                   mem_wr,
    output logic                                   busy
);

    localparam int unsigned IDX_W = (NUM_REGS_PER_DIR > 1) ? $clog2(NUM_REGS_PER_DIR) : 1;

    state_e      state_q, state_nx;
    cmd_t        cmd_q, cmd_nx;
    logic [1:0]  data_cnt_q, data_cnt_nx;
    logic        wait_q, wait_nx;
    logic        idx_ok_c, in_get_c, timeout_c;
    logic        reg_wr_c, mem_wr_c, mem_rd_c;
    logic        ser_load_c, ser_four_c, ser_done_c;
    logic [31:0] ser_word_c;
    logic [7:0]  ser_tx_byte;
    logic        ser_tx_valid;

    assign idx_ok_c = cmd_q.idx < 8'(NUM_REGS_PER_DIR);
    assign in_get_c = (state_q == ST_GET_IDX) || (state_q == ST_GET_ADDR_H) ||
                      (state_q == ST_GET_ADDR_L) || (state_q == ST_GET_DATA);

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    assign timeout_c = in_get_c && !uart.rx_byte_valid &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, cleared by every accepted byte and outside GET_*
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (in_get_c && !uart.rx_byte_valid && !timeout_c) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES) ^ in_get_c;
    assign timeout_c      = 1'b0;
`endif

    // Next-state and execute controls
    always_comb begin
        state_nx    = state_q;
        cmd_nx      = cmd_q;
        data_cnt_nx = data_cnt_q;
        wait_nx     = 1'b0;
        reg_wr_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_rd_c    = 1'b0;
        ser_load_c  = 1'b0;
        ser_four_c  = 1'b0;
        ser_word_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (uart.rx_byte_valid) begin
                    cmd_nx.op   = opcode_e'(uart.rx_byte[7:6]);
                    data_cnt_nx = 2'd0;
                    state_nx    = uart.rx_byte[7] ? ST_GET_ADDR_H : ST_GET_IDX;
                end
            end
            ST_GET_IDX: begin
                if (uart.rx_byte_valid) begin
                    cmd_nx.idx = uart.rx_byte;
                    state_nx   = (cmd_q.op == OP_REG_WR) ? ST_GET_DATA : ST_EXEC;
                end
            end
            ST_GET_ADDR_H: begin
                if (uart.rx_byte_valid) begin
                    cmd_nx.addr[8] = uart.rx_byte[0];
                    state_nx       = ST_GET_ADDR_L;
                end
            end
            ST_GET_ADDR_L: begin
                if (uart.rx_byte_valid) begin
                    cmd_nx.addr[7:0] = uart.rx_byte;
                    state_nx         = (cmd_q.op == OP_MEM_WR) ? ST_GET_DATA : ST_EXEC;
                end
            end
            ST_GET_DATA: begin
                if (uart.rx_byte_valid) begin
                    cmd_nx.data = {cmd_q.data[23:0], uart.rx_byte};
                    data_cnt_nx = data_cnt_q + 2'd1;
                    if (data_cnt_q == 2'd3) begin
                        state_nx = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_nx   = ST_SEND;
                ser_load_c = 1'b1;
                ser_word_c = {24'h0, ACK_BYTE};
                case (cmd_q.op)
                    OP_REG_WR: begin
                        reg_wr_c = idx_ok_c;
                        if (!idx_ok_c) ser_word_c = {24'h0, ERR_BYTE};
                    end
                    OP_REG_RD: begin
                        if (idx_ok_c) begin
                            ser_word_c = intrfc_regs_out[cmd_q.idx[IDX_W-1:0]];
                            ser_four_c = 1'b1;
                        end else begin
                            ser_word_c = {24'h0, ERR_BYTE};
                        end
                    end
                    OP_MEM_WR: mem_wr_c = 1'b1;
                    default: begin
                        mem_rd_c   = 1'b1;
                        ser_load_c = 1'b0;
                        state_nx   = ST_MEM_WAIT;
                    end
                endcase
            end
            // Address registered on entry, memory output valid one cycle later
            ST_MEM_WAIT: begin
                if (wait_q) begin
                    ser_load_c = 1'b1;
                    ser_four_c = 1'b1;
                    ser_word_c = mem_rd_data;
                    state_nx   = ST_SEND;
                end else begin
                    wait_nx = 1'b1;
                end
            end
            ST_SEND: begin
                if (ser_done_c) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        if (timeout_c) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            data_cnt_q <= '0;
            wait_q     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_nx;
            cmd_q      <= cmd_nx;
            data_cnt_q <= data_cnt_nx;
            wait_q     <= wait_nx;
            busy       <= (state_nx != ST_IDLE);
        end
    end

    // Register and memory side effects, valid strobes last exactly one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            intrfc_regs_in             <= '0;
            intrfc_regs_in_valid_pulse <= '0;
            mem_addr                   <= '0;
            mem_wr_data                <= '0;
            mem_wr                     <= 1'b0;
        end else begin
            intrfc_regs_in_valid_pulse <= '0;
            mem_wr                     <= mem_wr_c;
            if (reg_wr_c) begin
                intrfc_regs_in[cmd_q.idx[IDX_W-1:0]] <= cmd_q.data;
                intrfc_regs_in_valid_pulse <= NUM_REGS_PER_DIR'(1) << cmd_q.idx[IDX_W-1:0];
            end
            if (mem_wr_c || mem_rd_c) mem_addr <= cmd_q.addr;
            if (mem_wr_c) mem_wr_data <= cmd_q.data;
        end
    end

    uart_bridge_resp_ser u_resp_ser (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (ser_load_c),
        .load_word     (ser_word_c),
        .load_four     (ser_four_c),
        .tx_byte       (ser_tx_byte),
        .tx_byte_valid (ser_tx_valid),
        .tx_byte_ready (uart.tx_byte_ready),
        .done_c        (ser_done_c)
    );

    assign uart.tx_byte       = ser_tx_byte;
    assign uart.tx_byte_valid = ser_tx_valid;

endmodule

// File: tb/tb_uart_regs_bridge.sv
// Scoreboard bench for uart_regs_bridge: directed commands, queued expectations, async monitors.
module tb_uart_regs_bridge;

    localparam int unsigned NREGS = 8;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NREGS-1:0][31:0]      regs_in;
    logic [NREGS-1:0]            pulse;
    logic [NREGS-1:0][31:0]      regs_out;
    logic [8:0]                  mem_addr;
    logic [31:0]                 mem_wr_data;
    logic [31:0]                 mem_rd_data;
    logic                        mem_wr;
    logic                        busy;

    uart_regs_bridge_if u_if ();

    uart_regs_bridge #(
        .NUM_REGS_PER_DIR (NREGS),
        .TIMEOUT_CYCLES   (100)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .uart                       (u_if),
        .intrfc_regs_in             (regs_in),
        .intrfc_regs_in_valid_pulse (pulse),
        .intrfc_regs_out            (regs_out),
        .mem_addr                   (mem_addr),
        .mem_wr_data                (mem_wr_data),
        .mem_rd_data                (mem_rd_data),
        .mem_wr                     (mem_wr),
        .busy                       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_tx_q [$];
    logic [7:0]  exp_pulse_q [$];
    logic [40:0] exp_mem_q [$];
    logic [31:0] exp_regs [NREGS];
    bit          ready_toggle = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmit monitor: every transfer pops one expected byte; stalls must hold tx_byte
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("tx_stall_valid", 64'(u_if.tx_byte_valid), 64'd1);
                check("tx_stall_byte", 64'(u_if.tx_byte), 64'(prev_byte));
            end
            if (u_if.tx_byte_valid && u_if.tx_byte_ready) begin
                if (exp_tx_q.size() == 0) check("tx_unexpected", 64'(u_if.tx_byte), 64'h1FF);
                else check("tx_byte", 64'(u_if.tx_byte), 64'(exp_tx_q.pop_front()));
            end
            prev_stall = u_if.tx_byte_valid && !u_if.tx_byte_ready;
            prev_byte  = u_if.tx_byte;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Strobe monitor: pulse/mem_wr payloads popped and checked, never two cycles wide
    logic [NREGS-1:0] prev_pulse = '0;
    logic             prev_mem_wr = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pulse != '0) begin
                check("pulse_width", 64'(prev_pulse), 64'd0);
                if (exp_pulse_q.size() == 0) check("pulse_unexpected", 64'(pulse), 64'd0);
                else check("pulse_mask", 64'(pulse), 64'(exp_pulse_q.pop_front()));
            end
            if (mem_wr) begin
                check("mem_wr_width", 64'(prev_mem_wr), 64'd0);
                if (exp_mem_q.size() == 0) check("mem_wr_unexpected", 64'(mem_wr), 64'd0);
                else check("mem_wr_addr_data", 64'({mem_addr, mem_wr_data}), 64'(exp_mem_q.pop_front()));
            end
            prev_pulse  = pulse;
            prev_mem_wr = mem_wr;
        end else begin
            prev_pulse  = '0;
            prev_mem_wr = 1'b0;
        end
    end

    // tx_byte_ready driver: tied high or toggling every cycle
    initial begin
        u_if.tx_byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_if.tx_byte_ready = ready_toggle ? ~u_if.tx_byte_ready : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        u_if.rx_byte       = b;
        u_if.rx_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.rx_byte_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_tx_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((exp_tx_q.size() != 0 || busy) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_drain_timeout"}, 64'(cyc >= 200), 64'd0);
        check({name, "_tx_left"}, 64'(exp_tx_q.size()), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NREGS; i++) check(name, 64'(regs_in[i]), 64'(exp_regs[i]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.rx_byte       = 8'h00;
        u_if.rx_byte_valid = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | 32'(i);
        for (int i = 0; i < NREGS; i++) regs_out[i] = 32'h5500_0000 | 32'(i);
        regs_out[0] = 32'hCAFE_0000;
        regs_out[2] = 32'h0BAD_F00D;
        regs_out[3] = 32'h1234_5678;

        #1;
        do_reset();
        check("rst_pulse", 64'(pulse), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_tx_byte", 64'(u_if.tx_byte), 64'd0);
        check("rst_tx_valid", 64'(u_if.tx_byte_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check_regs("rst_regs_in");

        // REG_WR reg 1
        exp_pulse_q.push_back(8'b0000_0010);
        exp_tx_q.push_back(8'hA5);
        exp_regs[1] = 32'hDEAD_BEEF;
        foreach (u8_wr1[i]) send_byte(u8_wr1[i]);
        drain("reg_wr1");
        check_regs("reg_wr1_regs");

        // REG_RD reg 3, ready tied high then toggling
        push_word(32'h1234_5678);
        send_byte(8'h40); send_byte(8'h03);
        drain("reg_rd3");
        ready_toggle = 1'b1;
        push_word(32'h1234_5678);
        send_byte(8'h40); send_byte(8'h03);
        drain("reg_rd3_stall");
        ready_toggle = 1'b0;

        // MEM_WR 0x123 <= 0x2A, then read back
        exp_mem_q.push_back({9'h123, 32'h0000_002A});
        exp_tx_q.push_back(8'hA5);
        foreach (u8_mw[i]) send_byte(u8_mw[i]);
        drain("mem_wr");
        check("mem_addr_hold", 64'(mem_addr), 64'h123);
        check("mem_wr_data_hold", 64'(mem_wr_data), 64'h2A);
        push_word(32'h0000_002A);
        send_byte(8'hC0); send_byte(8'h01); send_byte(8'h23);
        drain("mem_rd");

        // MEM_RD with ignored opcode/addrH bits: addr 0x055 preloaded pattern
        push_word(32'hA000_0055);
        send_byte(8'hFE); send_byte(8'hFE); send_byte(8'h55);
        drain("mem_rd_ign");

        // Out-of-range indices
        exp_tx_q.push_back(8'hEE);
        send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        drain("reg_wr_bad");
        check_regs("reg_wr_bad_regs");
        exp_tx_q.push_back(8'hEE);
        send_byte(8'h40); send_byte(8'h09);
        drain("reg_rd_bad");

        // Top index with junk low opcode bits
        exp_pulse_q.push_back(8'b1000_0000);
        exp_tx_q.push_back(8'hA5);
        exp_regs[7] = 32'h0102_0304;
        send_byte(8'h3F); send_byte(8'h07);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        drain("reg_wr7");
        check_regs("reg_wr7_regs");

        // Reset in the middle of a REG_WR aborts it
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h11);
        do_reset();
        check_regs("mid_rst_regs");
        check("mid_rst_pulse", 64'(pulse), 64'd0);
        push_word(32'hCAFE_0000);
        send_byte(8'h40); send_byte(8'h00);
        drain("post_rst_rd0");
        check_regs("post_rst_regs");

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Partial command abandoned after the idle limit
        send_byte(8'h00); send_byte(8'h02);
        repeat (100) @(posedge clk);
        #1;
        push_word(32'h0BAD_F00D);
        send_byte(8'h40); send_byte(8'h02);
        drain("timeout");
        check_regs("timeout_regs");
`endif

        check("pulse_q_left", 64'(exp_pulse_q.size()), 64'd0);
        check("mem_q_left", 64'(exp_mem_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    logic [7:0] u8_wr1 [6] = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] u8_mw  [7] = '{8'h80, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00, 8'h2A};

endmodule
